pkt_cache_wr: RTL and testbench

- Write-side data controller between the ingress packet stream and the 16 x 128-word packet data cache.
- Receives a free buffer base address from the address manager and writes one packet into that buffer.
- Returns a commit or release handshake to the address manager, and emits a descriptor (base, length) to the downstream queue stage.

---
 rtl/pkt_cache_wr_pkg.sv | 14 +
 rtl/pkt_cache_wr.sv | 121 ++++++++++++
 tb/tb_pkt_cache_wr.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pkt_cache_wr_pkg.sv
// pkt_cache_wr_pkg: shared widths and FSM encoding for the packet cache write side.
package pkt_cache_wr_pkg;
  localparam int BUF_AW = 7;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 8;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    WRITE   = 3'd2,
    COMMIT  = 3'd3,
    DROP    = 3'd4,
    RELEASE = 3'd5
  } state_t;
endpackage

// File: rtl/pkt_cache_wr.sv
// pkt_cache_wr: writes one ingress packet into a granted cache buffer, then commits or releases it.
module pkt_cache_wr
  import pkt_cache_wr_pkg::*;
#(
  parameter int DW        = 134,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_pkt_data,
  input  logic              in_pkt_data_wr,
  input  logic              in_pkt_head,
  input  logic              in_pkt_tail,
  output logic              out_pkt_ready,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_waddr_wr,
  output logic [ADDR_W-1:0] out_ram_waddr,
  output logic [DW-1:0]     out_ram_wdata,
  output logic              out_ram_wr,
  output logic              out_addr_mgmt_valid,
  output logic              out_addr_mgmt_valid_wr,
  output logic [ADDR_W-1:0] out_desc_addr,
  output logic [LEN_W-1:0]  out_desc_len,
  output logic              out_desc_wr
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic mgmt_valid_q, mgmt_valid_d;
  logic mgmt_wr_q, mgmt_wr_d;
  logic [ADDR_W-1:0] desc_addr_q, desc_addr_d;
  logic [LEN_W-1:0] desc_len_q, desc_len_d;
  logic desc_wr_q, desc_wr_d;
  logic acc, commit, release_b;
  assign out_pkt_ready = (state_q == ARMED) || (state_q == WRITE) || (state_q == DROP);
  assign acc = in_pkt_data_wr & out_pkt_ready;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    cnt_d = cnt_q;
    ram_wr_d = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: if (in_waddr_wr) begin
        base_d = in_waddr;
        cnt_d = '0;
        state_d = ARMED;
      end
      ARMED: if (acc && in_pkt_head) begin
        ram_wr_d = 1'b1;
        ram_waddr_d = base_q;
        ram_wdata_d = in_pkt_data;
        cnt_d = LEN_W'(1);
        state_d = in_pkt_tail ? COMMIT : WRITE;
      end
      WRITE: if (acc) begin
        if (cnt_q == LEN_W'(MAX_WORDS)) begin
          state_d = in_pkt_tail ? RELEASE : DROP;
        end else begin
          ram_wr_d = 1'b1;
          ram_waddr_d = {base_q[ADDR_W-1:BUF_AW], cnt_q[BUF_AW-1:0]};
          ram_wdata_d = in_pkt_data;
          cnt_d = cnt_q + LEN_W'(1);
          state_d = in_pkt_tail ? COMMIT : WRITE;
        end
      end
      DROP: state_d = (acc && in_pkt_tail) ? RELEASE : DROP;
      COMMIT, RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Strobes are registered on entry so they line up with the final RAM write.
  always_comb begin
    commit = (state_d == COMMIT) && (state_q != COMMIT);
    release_b = (state_d == RELEASE) && (state_q != RELEASE);
    mgmt_wr_d = commit || release_b;
    mgmt_valid_d = commit;
    desc_wr_d = commit;
    desc_addr_d = commit ? base_q : '0;
    desc_len_d = commit ? cnt_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      ram_wr_q <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      mgmt_valid_q <= 1'b0;
      mgmt_wr_q <= 1'b0;
      desc_addr_q <= '0;
      desc_len_q <= '0;
      desc_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      ram_wr_q <= ram_wr_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      mgmt_valid_q <= mgmt_valid_d;
      mgmt_wr_q <= mgmt_wr_d;
      desc_addr_q <= desc_addr_d;
      desc_len_q <= desc_len_d;
      desc_wr_q <= desc_wr_d;
    end
  end
  assign out_ram_wr = ram_wr_q;
  assign out_ram_waddr = ram_waddr_q;
  assign out_ram_wdata = ram_wdata_q;
  assign out_addr_mgmt_valid = mgmt_valid_q;
  assign out_addr_mgmt_valid_wr = mgmt_wr_q;
  assign out_desc_addr = desc_addr_q;
  assign out_desc_len = desc_len_q;
  assign out_desc_wr = desc_wr_q;
endmodule

// File: tb/tb_pkt_cache_wr.sv
// tb_pkt_cache_wr: directed checks of buffer fill, commit, drop/release and reset behaviour.
module tb_pkt_cache_wr;
  localparam int DW = 134;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] in_pkt_data = '0;
  logic in_pkt_data_wr = 1'b0;
  logic in_pkt_head = 1'b0;
  logic in_pkt_tail = 1'b0;
  logic out_pkt_ready;
  logic [10:0] in_waddr = '0;
  logic in_waddr_wr = 1'b0;
  logic [10:0] out_ram_waddr;
  logic [DW-1:0] out_ram_wdata;
  logic out_ram_wr;
  logic out_addr_mgmt_valid;
  logic out_addr_mgmt_valid_wr;
  logic [10:0] out_desc_addr;
  logic [7:0] out_desc_len;
  logic out_desc_wr;
  int total = 0;
  int bad = 0;
  pkt_cache_wr #(.DW(DW), .MAX_WORDS(128)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_pkt_data(in_pkt_data),
    .in_pkt_data_wr(in_pkt_data_wr),
    .in_pkt_head(in_pkt_head),
    .in_pkt_tail(in_pkt_tail),
    .out_pkt_ready(out_pkt_ready),
    .in_waddr(in_waddr),
    .in_waddr_wr(in_waddr_wr),
    .out_ram_waddr(out_ram_waddr),
    .out_ram_wdata(out_ram_wdata),
    .out_ram_wr(out_ram_wr),
    .out_addr_mgmt_valid(out_addr_mgmt_valid),
    .out_addr_mgmt_valid_wr(out_addr_mgmt_valid_wr),
    .out_desc_addr(out_desc_addr),
    .out_desc_len(out_desc_len),
    .out_desc_wr(out_desc_wr)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mk(input int k);
    return {6'(k), 128'(k) * 128'h9E3779B97F4A7C15};
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic dwr, input logic [DW-1:0] d, input logic h,
                      input logic t, input logic awr, input logic [10:0] a, input logic exp_rdy,
                      input logic exp_wr, input logic [10:0] exp_addr);
    @(negedge clk);
    in_pkt_data_wr = dwr;
    in_pkt_data = d;
    in_pkt_head = h;
    in_pkt_tail = t;
    in_waddr_wr = awr;
    in_waddr = a;
    chk({tag, " ready"}, DW'(out_pkt_ready), DW'(exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " ram_wr"}, DW'(out_ram_wr), DW'(exp_wr));
    if (exp_wr) begin
      chk({tag, " ram_waddr"}, DW'(out_ram_waddr), DW'(exp_addr));
      chk({tag, " ram_wdata"}, out_ram_wdata, d);
    end
  endtask
  task automatic word(input string tag, input int k, input logic h, input logic t,
                      input logic exp_rdy, input logic exp_wr, input logic [10:0] exp_addr);
    step(tag, 1'b1, mk(k), h, t, 1'b0, 11'h0, exp_rdy, exp_wr, exp_addr);
  endtask
  task automatic base(input string tag, input logic [10:0] a);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0, 11'h0);
  endtask
  task automatic idle(input string tag, input logic exp_rdy);
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 11'h0, exp_rdy, 1'b0, 11'h0);
  endtask
  task automatic strb(input string tag, input logic vwr, input logic v, input logic dwr,
                      input logic [10:0] da, input logic [7:0] dl);
    chk({tag, " valid_wr"}, DW'(out_addr_mgmt_valid_wr), DW'(vwr));
    chk({tag, " valid"}, DW'(out_addr_mgmt_valid), DW'(v));
    chk({tag, " desc_wr"}, DW'(out_desc_wr), DW'(dwr));
    chk({tag, " desc_addr"}, DW'(out_desc_addr), DW'(da));
    chk({tag, " desc_len"}, DW'(out_desc_len), DW'(dl));
  endtask
  task automatic all_zero(input string tag);
    chk({tag, " ready"}, DW'(out_pkt_ready), '0);
    chk({tag, " ram_wr"}, DW'(out_ram_wr), '0);
    chk({tag, " ram_waddr"}, DW'(out_ram_waddr), '0);
    chk({tag, " ram_wdata"}, out_ram_wdata, '0);
    strb(tag, 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    word("no_base", 1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    word("no_base2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    base("b080", 11'h080);
    word("pre_head", 9, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0);
    word("p4_w0", 11, 1'b1, 1'b0, 1'b1, 1'b1, 11'h080);
    step("p4_w1", 1'b1, mk(12), 1'b0, 1'b0, 1'b1, 11'h300, 1'b1, 1'b1, 11'h081);
    word("p4_w2", 13, 1'b1, 1'b0, 1'b1, 1'b1, 11'h082);
    word("p4_w3", 14, 1'b0, 1'b1, 1'b1, 1'b1, 11'h083);
    strb("p4_commit", 1'b1, 1'b1, 1'b1, 11'h080, 8'd4);
    idle("p4_after", 1'b0);
    strb("p4_quiet", 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    step("same_cycle", 1'b1, mk(20), 1'b1, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, 11'h0);
    word("p1_w0", 21, 1'b1, 1'b1, 1'b1, 1'b1, 11'h000);
    strb("p1_commit", 1'b1, 1'b1, 1'b1, 11'h000, 8'd1);
    idle("p1_commit_rdy", 1'b0);
    idle("p1_idle_rdy", 1'b0);
    base("b780", 11'h780);
    for (int k = 0; k < 128; k++)
      word("p128", 100 + k, k == 0, k == 127, 1'b1, 1'b1, 11'h780 + 11'(k));
    strb("p128_commit", 1'b1, 1'b1, 1'b1, 11'h780, 8'd128);
    idle("p128_after", 1'b0);
    base("b100", 11'h100);
    for (int k = 0; k < 130; k++)
      word("p130", 300 + k, k == 0, k == 129, 1'b1, k < 128, 11'h100 + 11'(k));
    strb("p130_release", 1'b1, 1'b0, 1'b0, 11'h0, 8'h0);
    idle("p130_rel_rdy", 1'b0);
    strb("p130_quiet", 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    word("p130_wait_base", 500, 1'b1, 1'b1, 1'b0, 1'b0, 11'h0);
    base("b200", 11'h200);
    for (int k = 0; k < 10; k++)
      word("p10", 600 + k, k == 0, 1'b0, 1'b1, 1'b1, 11'h200 + 11'(k));
    rst_n = 1'b0;
    in_pkt_data_wr = 1'b0;
    in_pkt_head = 1'b0;
    in_pkt_tail = 1'b0;
    #1;
    all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle("post_reset", 1'b0);
      strb("post_reset", 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    end
    base("b200b", 11'h200);
    word("p2_w0", 700, 1'b1, 1'b0, 1'b1, 1'b1, 11'h200);
    word("p2_w1", 701, 1'b0, 1'b1, 1'b1, 1'b1, 11'h201);
    strb("p2_commit", 1'b1, 1'b1, 1'b1, 11'h200, 8'd2);
    idle("p2_after", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
